// File: rtl/temporizador_antirrebote_pkg.sv
// Shared types for the debounce timer responder.
// State encoding and prescaler divide derivation.
package temporizador_antirrebote_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRE  = 2'd2,
    HOLD  = 2'd3
  } estado_e;

  function automatic int tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/temporizador_canal.sv
// One request/done channel: counts ms ticks while the
// request is held, then pulses done once per request.
module temporizador_canal
  import temporizador_antirrebote_pkg::*;
#(
  parameter int TIMEOUT_MS = 300
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic tick,
  input  logic req,
  output logic done,
  output logic busy
);

  localparam int CW = $clog2(TIMEOUT_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_MS - 1);

  estado_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) state_d = COUNT;
      end
      COUNT: begin
        // a dropped request wins over a tick on the same cycle
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == LAST) state_d = FIRE;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: state_d = HOLD;
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign done = (state_q == FIRE);
  assign busy = (state_q != IDLE);

endmodule

// File: rtl/temporizador_antirrebote.sv
// Debounce timer responder: shared free-running 1 ms
// prescaler feeding N_CH independent timeout channels.
module temporizador_antirrebote
  import temporizador_antirrebote_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_MS = 300,
  parameter int N_CH       = 1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [N_CH-1:0] actCuenta,
  output logic [N_CH-1:0] t300ms,
  output logic [N_CH-1:0] ocupado,
  output logic            tick_ms
);

  localparam int TICK_DIV = tick_div(CLK_HZ);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) presc_q <= '0;
    else presc_q <= presc_d;
  end

  assign tick_ms = (presc_q == PLAST);
  assign presc_d = tick_ms ? '0 : presc_q + 1'b1;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    temporizador_canal #(
      .TIMEOUT_MS(TIMEOUT_MS)
    ) u_canal (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .tick   (tick_ms),
      .req    (actCuenta[i]),
      .done   (t300ms[i]),
      .busy   (ocupado[i])
    );
  end

endmodule

// File: tb/tb_temporizador_antirrebote.sv
// Scoreboard bench for temporizador_antirrebote with
// directed phases and randomized request patterns.
module tb_temporizador_antirrebote;

  localparam int TD = 10;
  localparam int TO = 3;
  localparam int MAXC = 256;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic [1:0] actCuenta;
  logic [1:0] t300ms;
  logic [1:0] ocupado;
  logic       tick_ms;

  temporizador_antirrebote #(
    .CLK_HZ    (10_000),
    .TIMEOUT_MS(TO),
    .N_CH      (2)
  ) dut (
    .Clk      (clk),
    .Reset_n  (Reset_n),
    .actCuenta(actCuenta),
    .t300ms   (t300ms),
    .ocupado  (ocupado),
    .tick_ms  (tick_ms)
  );

  always #5 clk = ~clk;

  logic [1:0] stim [0:MAXC-1];
  bit         exp_busy [0:1][0:MAXC-1];
  int         q0[$];
  int         q1[$];
  int         total;
  int         bad;
  int         cur_cycle;

  task automatic chk(input string nm, input int cyc,
                     input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d",
               nm, cyc, got, want);
    end
  endtask

  task automatic clr_stim();
    for (int n = 0; n < MAXC; n++) stim[n] = 2'b00;
  endtask

  task automatic set_run(input int ch, input int a, input int b);
    for (int n = a; n <= b; n++) stim[n][ch] = 1'b1;
  endtask

  task automatic rand_stim(input int len);
    int r;
    int n;
    bit v;
    for (int ch = 0; ch < 2; ch++) begin
      n = 0;
      v = bit'($urandom_range(0, 1));
      while (n < len) begin
        r = v ? int'($urandom_range(3, 60)) : int'($urandom_range(1, 12));
        for (int k = 0; k < r && n < len; k++) begin
          stim[n][ch] = v;
          n++;
        end
        v = !v;
      end
    end
  endtask

  // Reference: each accepted request is an episode with a
  // deadline at the TO-th tick strictly after acceptance.
  task automatic build_model(input int len);
    int n, s, t1, tl, d, h, e;
    bit ab;
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < MAXC; k++) exp_busy[ch][k] = 1'b0;
      n = 0;
      while (n < len) begin
        if (!stim[n][ch]) begin
          n++;
        end else begin
          s  = n;
          t1 = (s / TD) * TD + TD - 1;
          if (t1 <= s) t1 += TD;
          tl = t1 + (TO - 1) * TD;
          ab = 1'b0;
          d  = s + 1;
          while (d <= tl && d < len && !ab) begin
            if (!stim[d][ch]) ab = 1'b1;
            else d++;
          end
          if (ab) begin
            e = d;
            n = d + 1;
          end else if (tl + 1 >= len) begin
            e = len - 1;
            n = len;
          end else begin
            if (ch == 0) q0.push_back(tl + 1);
            else q1.push_back(tl + 1);
            h = tl + 2;
            while (h < len && stim[h][ch]) h++;
            e = (h < len) ? h : len - 1;
            n = h + 1;
          end
          for (int k = s + 1; k <= e; k++) exp_busy[ch][k] = 1'b1;
        end
      end
    end
  endtask

  task automatic run_phase(input int len);
    q0.delete();
    q1.delete();
    build_model(len);
    Reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Reset_n = 1'b1;
    for (int n = 0; n < len; n++) begin
      cur_cycle = n;
      actCuenta = stim[n];
      #1;
      chk("tick_ms", n, int'(tick_ms), int'(n % TD == TD - 1));
      chk("ocupado0", n, int'(ocupado[0]), int'(exp_busy[0][n]));
      chk("ocupado1", n, int'(ocupado[1]), int'(exp_busy[1][n]));
      @(posedge clk);
      #1;
    end
    chk("missing_pulse0", len, q0.size(), 0);
    chk("missing_pulse1", len, q1.size(), 0);
    Reset_n = 1'b0;
    #1;
    chk("rst_t300ms", len, int'(t300ms), 0);
    chk("rst_ocupado", len, int'(ocupado), 0);
    chk("rst_tick_ms", len, int'(tick_ms), 0);
  endtask

  always @(negedge clk) begin : mon
    int e;
    if (Reset_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (t300ms[ch]) begin
          total++;
          if ((ch == 0 && q0.size() == 0) ||
              (ch == 1 && q1.size() == 0)) begin
            bad++;
            $display("FAIL t300ms%0d cycle=%0d got=pulse want=none",
                     ch, cur_cycle);
          end else begin
            if (ch == 0) e = q0.pop_front();
            else e = q1.pop_front();
            if (e != cur_cycle) begin
              bad++;
              $display("FAIL t300ms%0d got=cycle %0d want=cycle %0d",
                       ch, cur_cycle, e);
            end
          end
        end
      end
    end
  end

  initial begin
    Reset_n   = 1'b0;
    actCuenta = 2'b00;
    total     = 0;
    bad       = 0;
    cur_cycle = 0;

    clr_stim();
    run_phase(45);

    clr_stim();
    set_run(0, 2, 40);
    run_phase(60);

    clr_stim();
    set_run(0, 2, 15);
    set_run(0, 21, 60);
    run_phase(70);

    clr_stim();
    set_run(0, 2, 101);
    run_phase(110);

    clr_stim();
    set_run(0, 2, 60);
    set_run(1, 12, 60);
    run_phase(70);

    clr_stim();
    set_run(0, 2, 50);
    set_run(1, 2, 50);
    run_phase(60);

    // reset lands while ch0 is mid-count
    clr_stim();
    set_run(0, 2, 30);
    run_phase(21);

    clr_stim();
    set_run(0, 0, 50);
    run_phase(60);

    repeat (8) begin
      clr_stim();
      rand_stim(200);
      run_phase(200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
